seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
Parametrised multi-digit multiplexed seven-segment driver. It is the next generation of the board's two-digit encoder display. It captures a binary value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per cycle). It then time-multiplexes NUM_DIGITS common-anode digits, with optional leading-zero blanking, overflow indication and selectable output polarity. It sits between any binary counter or encoder datapath and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
VALUE_WIDTH, 14, width of binary input value (1..27)
REFRESH_CYCLES, 100000, clk cycles each digit is held (1 ms at 100 MHz); minimum 2
ACTIVE_LOW, 1, 1: anodes and segments are driven low-active; 0: all of an and seg are inverted

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  display enable (switch); 0 blanks all digits
value  input  VALUE_WIDTH  unsigned binary value to display
load  input  1  single-cycle strobe: capture value and start conversion
blank_lz  input  1  1: suppress leading zeros (digit 0 always shown)
an  output  NUM_DIGITS  digit anode enables, one-hot-active while scanning
seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
busy  output  1  conversion in progress
overflow  output  1  last loaded value >= 10**NUM_DIGITS

Behaviour:
- Reset (rst_n=0 at a clk edge), polarity per ACTIVE_LOW=1:
  - an = all 1s; seg = 7'b1111111
  - busy = 0; overflow = 0
  - display register = all-zero BCD; scan counter = 0; digit index = 0
  - Reset mid-conversion aborts the conversion; no partial result is retained.
- Load handling:
  - load is sampled only when busy=0. A load while busy=1 is ignored; no queuing.
  - On an accepted load at edge N: value is captured, the BCD shift register is cleared, and the overflow flag is computed from a compare of value against the constant 10**NUM_DIGITS.
- Conversion:
  - busy=1 from edge N+1 through edge N+VALUE_WIDTH; one shift-add-3 iteration per cycle.
  - At edge N+VALUE_WIDTH+1: busy=0, overflow output updated, and the display register updated atomically.
  - The display never shows intermediate BCD.
  - The internal BCD width is sized for VALUE_WIDTH, not NUM_DIGITS. Overflow is not derived from BCD truncation.
- Scan (en=1):
  - The refresh counter counts 0..REFRESH_CYCLES-1.
  - On the terminal count it wraps to 0 and the digit index advances; index NUM_DIGITS-1 wraps to 0.
- Outputs:
  - an and seg are registered every cycle from the current digit index and the display register, so there is one cycle of lag.
  - an asserts only the bit for the current digit index.
- Decode, active-low (0 = lit):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
  - non-BCD nibble: 0111111 (dash)
- Overflow=1: every digit shows dash (0111111); blank_lz is ignored.
- Leading-zero blanking (blank_lz=1, overflow=0):
  - A digit at index k>0 is blanked if it and all higher digits are zero.
  - During a blanked digit's slot: an all inactive, seg all off; the scan timing is unchanged.
  - Value 0 shows a single "0" on digit 0.
- en=0:
  - From the next edge: an all inactive and seg all off.
  - Refresh counter and digit index are held at 0.
  - Conversion and load are unaffected.
  - On en rising, digit 0 is driven from the following edge for a full REFRESH_CYCLES.
- ACTIVE_LOW=0: an and seg are the bitwise inverse of the above in every case, including reset.
- Simultaneous load and conversion completion: busy is still 1 in that cycle, so the load is ignored.

Test Plan:
(All with NUM_DIGITS=4, VALUE_WIDTH=14, REFRESH_CYCLES=4, ACTIVE_LOW=1.)
1. Reset: hold rst_n=0 for 3 cycles with en=1 and load=1 -> an=1111, seg=1111111, busy=0, overflow=0; after release, digit 0 shows 1000000.
2. Load 1234, blank_lz=0, en=1 -> busy high exactly 14 cycles; then the scan sequence is:
   - an=1110/seg=0011001
   - an=1101/seg=0110000
   - an=1011/seg=0100100
   - an=0111/seg=1111001
   - each held 4 cycles, wrapping to digit 0.
3. Load 7 with blank_lz=1 -> digit 0 slot shows an=1110/seg=1111000; the other three slots show an=1111/seg=1111111. Load 0 -> only digit 0 shows 1000000.
4. Load 10000 -> overflow=1 after conversion; all four slots show seg=0111111. A following load of 9999 clears overflow and displays 9999.
5. Load 42, pulse load=1 with value 99 while busy -> display shows 42 and busy is not extended. Drop en mid-slot -> an=1111 next cycle; on raising en, digit 0 is shown for 4 cycles.
6. Assert rst_n=0 at conversion cycle 5 of a 1234 load -> busy=0 and the display register is zero; after release, 0 is displayed and no 1234 result appears.

Source files
------------

// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
//
// Multiplexed multi-digit seven-segment driver. A binary value is captured on
// a load strobe and converted to BCD one bit per cycle (shift-add-3). When the
// conversion finishes, the result is copied into the display register in a
// single step, so a half-converted number never reaches the digits. The
// digits are then scanned one at a time, each held for REFRESH_CYCLES clocks.
// Optional leading-zero blanking and an overflow dash pattern are supported.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst_n    - synchronous active-low reset
//   en       - display enable; 0 blanks every digit and parks the scan
//   value    - unsigned binary value to display (VALUE_WIDTH bits)
//   load     - single-cycle strobe: capture value and start a conversion
//   blank_lz - 1 suppresses leading zeros (digit 0 is always shown)
//   an       - digit anode enables (NUM_DIGITS bits)
//   seg      - segments {g,f,e,d,c,b,a}, bit 0 = a
//   busy     - conversion in progress
//   overflow - the last loaded value was >= 10**NUM_DIGITS
// ---------------------------------------------------------------------------
module seg_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int VALUE_WIDTH    = 14,
    parameter int REFRESH_CYCLES = 100000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   load,
    input  logic                   blank_lz,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [6:0]             seg,
    output logic                   busy,
    output logic                   overflow
);

    // Number of decimal digits needed for the largest VALUE_WIDTH-bit value.
    function automatic int calcBcdDigits(input int w);
        longint m;
        int     d;
        m = (longint'(1) << w) - 1;
        d = 1;
        while (m >= 10) begin
            m = m / 10;
            d = d + 1;
        end
        return d;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int BCD_DIGITS = calcBcdDigits(VALUE_WIDTH);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int SR_W       = BCD_W + VALUE_WIDTH;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int PAD_W      = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    localparam int CNT_W      = $clog2(VALUE_WIDTH + 1);
    localparam int REF_W      = $clog2(REFRESH_CYCLES);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [63:0]      OVF_LIMIT = 64'(pow10(NUM_DIGITS));
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(VALUE_WIDTH);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Internal segment patterns are always 0 = lit; polarity is applied last.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CONVERT
    } state_t;

    state_t                 state_q, state_d;
    logic [SR_W-1:0]        sr_q, sr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovfPend_q, ovfPend_d;
    logic                   ovf_q, ovf_d;
    logic [DISP_W-1:0]      disp_q, disp_d;
    logic [REF_W-1:0]       refCnt_q, refCnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic [PAD_W-1:0]       bcdPadded;

    // One double-dabble iteration on the combined {bcd, binary} register:
    // correct every BCD nibble that would exceed 9 after doubling, then shift.
    function automatic logic [SR_W-1:0] shiftAdd3(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[VALUE_WIDTH + 4*d +: 4] >= 4'd5) begin
                t[VALUE_WIDTH + 4*d +: 4] = t[VALUE_WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // All state lives here; reset aborts any conversion and drops its result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovfPend_q <= 1'b0;
            ovf_q     <= 1'b0;
            disp_q    <= '0;
            refCnt_q  <= '0;
            idx_q     <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovfPend_q <= ovfPend_d;
            ovf_q     <= ovf_d;
            disp_q    <= disp_d;
            refCnt_q  <= refCnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    // Conversion FSM. START is the cycle right after capture; busy is only
    // reported in CONVERT so it spans exactly VALUE_WIDTH cycles. A load seen
    // in START (busy still low) simply recaptures.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovfPend_d = ovfPend_q;
        ovf_d     = ovf_q;
        disp_d    = disp_q;
        bcdPadded = PAD_W'(sr_q[SR_W-1 -: BCD_W]);
        case (state_q)
            S_IDLE, S_START: begin
                if (load) begin
                    sr_d      = SR_W'(value);
                    cnt_d     = '0;
                    ovfPend_d = (64'(value) >= OVF_LIMIT);
                    state_d   = S_START;
                end else if (state_q == S_START) begin
                    sr_d    = shiftAdd3(sr_q);
                    cnt_d   = CNT_W'(1);
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CNT_LAST) begin
                    disp_d  = bcdPadded[DISP_W-1:0];
                    ovf_d   = ovfPend_q;
                    state_d = S_IDLE;
                end else begin
                    sr_d  = shiftAdd3(sr_q);
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Refresh counter and digit index; parked at zero while the display is off
    // so re-enabling always starts with a full slot on digit 0.
    always_comb begin
        refCnt_d = refCnt_q;
        idx_d    = idx_q;
        if (!en) begin
            refCnt_d = '0;
            idx_d    = '0;
        end else if (refCnt_q == REF_LAST) begin
            refCnt_d = '0;
            idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            refCnt_d = refCnt_q + REF_W'(1);
        end
    end

    // Next anode/segment pattern for the current slot. zeroRun walks down from
    // the most significant digit, so it is still set at digit k only when k
    // and every digit above it are zero.
    always_comb begin
        logic [NUM_DIGITS-1:0] anHigh;
        logic [6:0]            segLow;
        logic [3:0]            digitVal;
        logic                  curBlank;
        logic                  zeroRun;
        anHigh   = '0;
        segLow   = SEG_BLANK;
        digitVal = '0;
        curBlank = 1'b0;
        zeroRun  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeroRun = zeroRun & (disp_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                digitVal  = disp_q[4*k +: 4];
                curBlank  = zeroRun && (k != 0);
                anHigh[k] = 1'b1;
            end
        end
        if (!en) begin
            anHigh = '0;
            segLow = SEG_BLANK;
        end else if (ovf_q) begin
            segLow = SEG_DASH;
        end else if (blank_lz && curBlank) begin
            anHigh = '0;
            segLow = SEG_BLANK;
        end else begin
            segLow = decodeDigit(digitVal);
        end
        if (ACTIVE_LOW != 0) begin
            an_d  = ~anHigh;
            seg_d = segLow;
        end else begin
            an_d  = anHigh;
            seg_d = ~segLow;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign busy     = (state_q == S_CONVERT);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
//
// Bench for seg_scan_display with NUM_DIGITS=4, VALUE_WIDTH=14,
// REFRESH_CYCLES=4, ACTIVE_LOW=1. A table of values with hand-derived digit
// patterns drives full scan sweeps; directed sequences cover reset, ignored
// loads, enable toggling and reset mid-conversion; a random phase is checked
// every cycle against an arithmetic reference model of the display.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int VW = 14;
    localparam int RC = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [VW-1:0] value;
    logic          load;
    logic          blank_lz;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          busy;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    seg_scan_display #(
        .NUM_DIGITS    (ND),
        .VALUE_WIDTH   (VW),
        .REFRESH_CYCLES(RC),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .value   (value),
        .load    (load),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .busy    (busy),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [VW-1:0]    value;
        logic             blank;
        logic             expOvf;
        logic [3:0][6:0]  segExp;
        logic [3:0][3:0]  anExp;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: number on the display, pending conversion,
    // remaining conversion cycles and the scan position.
    int         mShown;
    int         mPend;
    bit         mOvf;
    int         mConv;
    int         mRef;
    int         mIdx;
    logic [3:0] mAn;
    logic [6:0] mSeg;

    function automatic logic [6:0] digitSeg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic int p10(input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic vec_t mkVec(input int v, input bit b, input bit o,
                                   input logic [27:0] s, input logic [15:0] a);
        vec_t r;
        r.value  = VW'(v);
        r.blank  = b;
        r.expOvf = o;
        r.segExp = s;
        r.anExp  = a;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelStep();
        logic [3:0] anN;
        logic [6:0] segN;
        bit         busyPre;
        anN  = 4'hF;
        segN = 7'h7F;
        if (en && !(!mOvf && blank_lz && mIdx > 0 && mShown < p10(mIdx))) begin
            anN  = ~(4'b0001 << mIdx);
            segN = mOvf ? 7'b0111111 : digitSeg((mShown / p10(mIdx)) % 10);
        end
        if (!rst_n) begin
            mShown = 0;
            mPend  = 0;
            mOvf   = 0;
            mConv  = 0;
            mRef   = 0;
            mIdx   = 0;
            anN    = 4'hF;
            segN   = 7'h7F;
        end else begin
            busyPre = (mConv >= 1 && mConv <= VW);
            if (!busyPre && load) begin
                mPend = int'(value);
                mConv = VW + 1;
            end else if (mConv == 1) begin
                mShown = mPend;
                mOvf   = (mPend >= p10(ND));
                mConv  = 0;
            end else if (mConv > 0) begin
                mConv = mConv - 1;
            end
            if (!en) begin
                mRef = 0;
                mIdx = 0;
            end else if (mRef == RC - 1) begin
                mRef = 0;
                mIdx = (mIdx + 1) % ND;
            end else begin
                mRef = mRef + 1;
            end
        end
        mAn  = anN;
        mSeg = segN;
    endtask

    // Cycle monitor: every output compared against the model after each edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("mon_an", an, mAn);
            checkOutput("mon_seg", seg, mSeg);
            checkOutput("mon_busy", busy, (mConv >= 1 && mConv <= VW));
            checkOutput("mon_overflow", overflow, mOvf);
        end
    end

    // Load a value; optionally pulse a second load injectAt cycles later.
    task automatic applyStimulus(input logic [VW-1:0] v, input logic b,
                                 input int injectAt, input logic [VW-1:0] injVal,
                                 output int busyCycles);
        bit done;
        blank_lz = b;
        value    = v;
        load     = 1'b1;
        tick();
        load       = 1'b0;
        busyCycles = 0;
        done       = 0;
        for (int g = 0; g < 40; g++) begin
            if (busy) busyCycles++;
            else if (busyCycles > 0) begin
                done = 1;
                break;
            end
            load = (g == injectAt);
            if (g == injectAt) value = injVal;
            tick();
        end
        load = 1'b0;
        checkOutput("conv_done_in_time", done, 1'b1);
    endtask

    // Park the scan with en=0, then sweep all four slots from digit 0.
    task automatic checkScan(input vec_t v);
        checkOutput("scan_overflow", overflow, v.expOvf);
        en = 1'b0;
        tick();
        checkOutput("en_off_an", an, 4'hF);
        checkOutput("en_off_seg", seg, 7'h7F);
        tick();
        en = 1'b1;
        for (int j = 0; j < 4 * RC; j++) begin
            tick();
            checkOutput($sformatf("scan_an_%0d_slot%0d", v.value, j / RC), an, v.anExp[j / RC]);
            checkOutput($sformatf("scan_seg_%0d_slot%0d", v.value, j / RC), seg, v.segExp[j / RC]);
        end
    endtask

    initial begin
        int   bc;
        vec_t zeroVec;

        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b1;
        value    = VW'(1234);
        blank_lz = 1'b0;

        repeat (3) begin
            tick();
            checkOutput("reset_an", an, 4'hF);
            checkOutput("reset_seg", seg, 7'h7F);
            checkOutput("reset_busy", busy, 1'b0);
            checkOutput("reset_overflow", overflow, 1'b0);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        tick();
        checkOutput("post_reset_an", an, 4'b1110);
        checkOutput("post_reset_seg", seg, 7'b1000000);

        vecs[0] = mkVec(1234, 0, 0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                        {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        vecs[1] = mkVec(7, 1, 0, {7'h7F, 7'h7F, 7'h7F, 7'b1111000},
                        {4'b1111, 4'b1111, 4'b1111, 4'b1110});
        vecs[2] = mkVec(0, 1, 0, {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                        {4'b1111, 4'b1111, 4'b1111, 4'b1110});
        vecs[3] = mkVec(10000, 1, 1, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111},
                        {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        vecs[4] = mkVec(9999, 0, 0, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000},
                        {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        vecs[5] = mkVec(305, 1, 0, {7'h7F, 7'b0110000, 7'b1000000, 7'b0010010},
                        {4'b1111, 4'b1011, 4'b1101, 4'b1110});
        vecs[6] = mkVec(8060, 0, 0, {7'b0000000, 7'b1000000, 7'b0000010, 7'b1000000},
                        {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        vecs[7] = mkVec(42, 1, 0, {7'h7F, 7'h7F, 7'b0011001, 7'b0100100},
                        {4'b1111, 4'b1111, 4'b1101, 4'b1110});

        // Entry 5 gets a load on the completion edge, entry 7 one mid-conversion;
        // both must be ignored.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].value, vecs[i].blank,
                          (i == 5) ? VW : ((i == 7) ? 6 : -1), VW'(99), bc);
            checkOutput($sformatf("busy_cycles_%0d", vecs[i].value), bc, VW);
            checkScan(vecs[i]);
        end

        // Drop en mid-slot while showing 42; digit 0 then gets a full slot.
        tick();
        tick();
        en = 1'b0;
        tick();
        checkOutput("en_drop_an", an, 4'hF);
        checkOutput("en_drop_seg", seg, 7'h7F);
        en = 1'b1;
        for (int j = 0; j < RC; j++) begin
            tick();
            checkOutput("en_rise_an", an, 4'b1110);
            checkOutput("en_rise_seg", seg, 7'b0100100);
        end
        tick();
        checkOutput("en_rise_next_an", an, 4'b1101);

        // Reset in the fifth busy cycle of a 1234 conversion.
        blank_lz = 1'b0;
        value    = VW'(1234);
        load     = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        checkOutput("midconv_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_an", an, 4'hF);
        rst_n = 1'b1;
        repeat (20) tick();
        zeroVec = mkVec(0, 0, 0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                        {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        checkScan(zeroVec);

        // Random phase, checked by the cycle monitor.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            load  = ($urandom_range(0, 5) == 0);
            value = ($urandom_range(0, 3) == 0) ? VW'($urandom_range(9990, 16383))
                                                : VW'($urandom_range(0, 9999));
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
            tick();
        end
        rst_n = 1'b1;
        load  = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
